// File: rtl/imm_ext_pipe.sv
// Pipelined immediate-extension stage between decode and execute.
// Valid/ready on both sides; a one-entry skid buffer absorbs a single cycle of backpressure.
module imm_ext_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [1:0]       out_mode
);

  typedef enum logic [1:0] {
    MODE_SIGN = 2'b00,
    MODE_ZERO = 2'b01,
    MODE_LUI  = 2'b10,
    MODE_BR2  = 2'b11
  } mode_e;

  localparam int PAD_W = OUT_W - IN_W;

  logic [OUT_W-1:0] sign_val;
  logic [OUT_W-1:0] zero_val;
  logic [OUT_W-1:0] lui_val;
  logic [OUT_W-1:0] br2_val;
  logic [OUT_W-1:0] ext_val;

  logic [OUT_W-1:0] skid_data;
  logic [1:0]       skid_mode;
  logic             skid_full;
  logic             skid_full_n;

  logic in_fire;
  logic out_free;

  // Size casts avoid zero-width replications when OUT_W == IN_W.
  assign sign_val = OUT_W'($signed(in_data));
  assign zero_val = OUT_W'(in_data);
  assign lui_val  = zero_val << PAD_W;
  assign br2_val  = sign_val << 2;

  always_comb begin
    ext_val = sign_val;
    case (mode_e'(in_mode))
      MODE_SIGN: ext_val = sign_val;
      MODE_ZERO: ext_val = zero_val;
      MODE_LUI:  ext_val = lui_val;
      MODE_BR2:  ext_val = br2_val;
      default:   ext_val = sign_val;
    endcase
  end

  assign in_fire  = in_valid && in_ready;
  assign out_free = out_ready || !out_valid;

  always_comb begin
    skid_full_n = skid_full;
    if (in_fire && !out_free) begin
      skid_full_n = 1'b1;
    end else if (out_free && !in_fire) begin
      skid_full_n = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_mode  <= '0;
      skid_full <= 1'b0;
      skid_data <= '0;
      skid_mode <= '0;
      in_ready  <= 1'b0;
    end else begin
      if (out_free) begin
        if (skid_full) begin
          out_data  <= skid_data;
          out_mode  <= skid_mode;
          out_valid <= 1'b1;
          if (in_fire) begin
            skid_data <= ext_val;
            skid_mode <= in_mode;
          end
        end else if (in_fire) begin
          out_data  <= ext_val;
          out_mode  <= in_mode;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (in_fire) begin
        skid_data <= ext_val;
        skid_mode <= in_mode;
      end
      skid_full <= skid_full_n;
      // Registered from next-state skid occupancy, so out_ready never reaches in_ready combinationally.
      in_ready  <= !skid_full_n;
    end
  end

endmodule

// File: doc/imm_ext_pipe.md
# imm_ext_pipe

Parametrised, pipelined immediate-extension unit for the MIPS datapath. It takes an IN_W-bit immediate plus a 2-bit mode and produces an OUT_W-bit operand. Modes are sign-extend, zero-extend, LUI placement, and branch-offset sign-extend with shift-by-2. It sits between decode and execute, uses a valid/ready handshake, and includes a one-entry skid buffer so backpressure from execute never drops or reorders immediates.

## Interface
Parameters:
- IN_W, 16, immediate input width; legal values are IN_W ≥ 2.
- OUT_W, 32, extended output width; legal values are OUT_W ≥ IN_W.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream immediate is valid.
- in_ready  output  1  unit can accept this cycle; registered.
- in_data  input  IN_W  raw immediate.
- in_mode  input  2  00 SIGN, 01 ZERO, 10 LUI, 11 BR2.
- out_valid  output  1  out_data/out_mode are valid; registered.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  OUT_W  extended operand; registered.
- out_mode  output  2  mode that produced out_data; registered.

## Operation
- Transfer rule: a transfer on a side occurs on a rising edge where valid && ready.
- Extension function f(d, m), computed combinationally at the input:
  - SIGN: replicate d[IN_W-1] into bits OUT_W-1..IN_W.
  - ZERO: fill bits OUT_W-1..IN_W with 0.
  - LUI: d goes in bits OUT_W-1..OUT_W-IN_W; the low OUT_W-IN_W bits are 0.
  - BR2: SIGN result shifted left by 2; the top 2 bits are discarded; bits 1..0 = 0.
  - Boundary: OUT_W == IN_W makes SIGN, ZERO and LUI all pass d through unchanged.
- Storage: output register (out_*) plus one skid register (skid_data, skid_mode, skid_full).
- Input accepted, output empty or draining (out_ready=1 or out_valid=0):
  - If skid_full=0, f result loads the output register.
  - If skid_full=1, the skid contents move to the output register and the new result enters the skid. This case is only reachable if in_ready was already 0, so it cannot occur.
- Input accepted, output stalled (out_valid=1, out_ready=0): the result goes to skid, skid_full←1, in_ready←0 next cycle.
- No input, output draining, skid_full=1: skid moves to output, skid_full←0, in_ready←1 next cycle.
- No input, output draining, skid_full=0: out_valid←0.
- Ordering: strict FIFO order, at most 2 entries in flight.
- Stability: out_data/out_mode hold stable while out_valid=1 && out_ready=0.
- in_ready is defined as !skid_full, registered. Upstream must hold in_data/in_mode stable while in_valid=1 && in_ready=0.

## Timing
- Reset asserted at an edge sets:
  - out_valid←0, out_data←0, out_mode←0
  - skid_full←0, skid_data←0
  - in_ready←1 from the first cycle after reset is released.
- While reset is asserted, in_ready reads 0 and no transfers occur.
- Reset mid-operation discards both the output entry and the skid entry. Nothing is delivered afterwards.
- Latency: input accepted at edge k gives out_valid=1 with the result in the cycle after edge k (1 cycle).
- Throughput: 1 immediate per cycle while out_ready=1 continuously.
- Stall then release:
  - The first stalled cycle fills the skid and drops in_ready.
  - The first out_ready=1 edge delivers the output entry and promotes the skid.
  - in_ready returns to 1 the next cycle.
  - No bubble appears on the output side.
- Simultaneous output drain and input accept with skid empty: the output register reloads in the same edge and out_valid stays 1.
- No combinational path from out_ready to in_ready.

## Test plan
- Modes, IN_W=16 / OUT_W=32, out_ready=1:
  - SIGN 16'h8000 → 32'hFFFF8000.
  - SIGN 16'h7FFF → 32'h00007FFF.
  - ZERO 16'hF333 → 32'h0000F333.
  - LUI 16'h1234 → 32'h12340000.
  - BR2 16'hFFFF → 32'hFFFFFFFC.
  - Each appears 1 cycle after acceptance with the matching out_mode.
- Back-to-back stream: 8 consecutive SIGN inputs 16'h0000..16'h0007 with out_ready=1 → 8 consecutive out_valid cycles carrying 32'h0..32'h7 in order, in_ready=1 throughout.
- Backpressure:
  - Send A=16'h8001 and B=16'h0002 (SIGN) while out_ready=0.
  - Required: out_data=32'hFFFF8001 held, in_ready=0 after B, third input not accepted.
  - Raise out_ready: A, then B (32'h00000002) on consecutive cycles; in_ready=1 one cycle after B is promoted.
- Reset mid-stall: with the output and skid both full, assert reset for one cycle → out_valid=0, out_data=0, in_ready=1 the cycle after release. Neither held entry is ever output.
- Parameter corner: IN_W=8, OUT_W=8 → SIGN/ZERO/LUI 8'hA5 all yield 8'hA5; BR2 8'hA5 yields 8'h94.
- Parameter corner: IN_W=12, OUT_W=64 → SIGN 12'h800 → 64'hFFFFFFFFFFFFF800.
